dac_frame_driver: RTL and testbench
===================================

Name: dac_frame_driver

Overview:
- Sits directly downstream of the DAC buffer de-interleaver. Paces the sample rate by pulsing dac_request, takes the atomically updated 4-channel sample, and shifts it out to a 4-lane serial DAC: shared SCLK/CS_N/LDAC_N, one SDI line per channel.
- Counts underruns reported upstream; on underrun, no frame is sent and the DAC holds its last value.
- Held in reset while the DAC pipe is closed; reset_n is driven from dac_open.

Parameters:
- SAMPLE_DIV, 256: capture_clk cycles per sample period. Minimum 2*SCLK_DIV*DATA_BITS + LDAC_CYCLES + 16.
- SCLK_DIV, 2: capture_clk cycles per SCLK half-period. Minimum 1.
- DATA_BITS, 24: bits shifted per channel, taken from the word's top bits [31:32-DATA_BITS]. Range 1..32.
- LDAC_CYCLES, 2: capture_clk cycles that ldac_n is held low after each frame. Minimum 1.
- READY_TIMEOUT, 8: cycles to wait for a response after dac_request before declaring the sample missed.

Ports:
- capture_clk  in  1  Sole clock.
- reset_n  in  1  Asynchronous, active-low reset.
- dac_request  out  1  One-cycle pulse per sample period.
- dac_buffer_ready  in  1  Upstream pulse: dac_buffer_flat holds the new sample.
- dac_underrun  in  1  Upstream pulse: no valid sample this period.
- dac_buffer_flat  in  128  Channel c occupies bits [32c+31:32c].
- dac_sclk  out  1  Serial clock; idles low.
- dac_cs_n  out  1  Frame select; low during shifting.
- dac_sdi  out  4  Bit c is the serial data for channel c, MSB first.
- dac_ldac_n  out  1  Load strobe; active-low.
- underrun_count  out  16  Saturating count of missed samples.
- frame_overrun  out  1  Sticky: a sample tick occurred while not in IDLE.
- busy  out  1  High in any state other than IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - dac_request=0, dac_cs_n=1, dac_sclk=0, dac_sdi=0, dac_ldac_n=1.
  - underrun_count=0, frame_overrun=0, busy=0.
  - State goes to IDLE; tick counter loads SAMPLE_DIV-1.
- Tick counter:
  - Free-running down-counter that reloads SAMPLE_DIV-1 after reaching 0.
  - The first tick occurs SAMPLE_DIV cycles after reset_n rises.
- States and transitions:
  - IDLE: on tick, dac_request=1 for that one cycle; go to WAIT.
  - WAIT: sample dac_buffer_ready / dac_underrun every cycle.
    - dac_buffer_ready=1: latch the DATA_BITS top bits of each channel into 4 shift registers; go to SHIFT. dac_buffer_ready has priority if both inputs are high.
    - dac_underrun=1: underrun_count += 1, saturating at 0xFFFF; no frame is sent; go to IDLE.
    - Neither input high within READY_TIMEOUT cycles of the request: count as an underrun; go to IDLE.
  - SHIFT:
    - First cycle: dac_cs_n=0, dac_sdi[c] = MSB of channel c.
    - dac_sclk toggles every SCLK_DIV cycles, starting low. The DAC samples on the rising edge.
    - On each falling edge, shift the next bit onto dac_sdi.
    - After the DATA_BITS-th falling edge: dac_cs_n=1, dac_sdi=0, dac_sclk=0; go to LOAD.
    - Total SHIFT length is 2*SCLK_DIV*DATA_BITS cycles.
  - LOAD: dac_ldac_n=0 for LDAC_CYCLES cycles, then 1; go to IDLE.
- Latency: dac_request to dac_cs_n low is 2 cycles when ready returns 1 cycle after the request.
- Tick while not in IDLE:
  - dac_request is suppressed and frame_overrun is set (cleared only by reset).
  - The current frame completes normally; the next tick is handled as usual.
- dac_buffer_ready or dac_underrun arriving outside WAIT is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: DAC_OFFSET_BINARY_EN.
- Defined: invert the MSB of each channel's DATA_BITS field when latching, converting two's complement to offset binary for unipolar-coded DACs.
- Undefined: data is shifted unmodified (two's complement).

Test Plan:
- Reset release, ready returned 1 cycle after each request, ch0..3 = 0x12345600 / 0xABCDEF00 / 0x80000000 / 0x7FFFFF00 -> first dac_request at cycle 256. Decoded SDI words: 0x123456, 0xABCDEF, 0x800000, 0x7FFFFF. Exactly 24 SCLK rising edges while cs_n is low. One ldac_n low pulse, 2 cycles long.
- dac_underrun pulsed instead of ready -> no cs_n activity that period, underrun_count=1. The next period with ready produces a normal frame.
- No response to a request for 8 cycles -> underrun_count increments, state returns to IDLE, no frame.
- SAMPLE_DIV=64 with defaults (frame ≥ 96 cycles) -> frame_overrun=1 at the second tick, dac_request suppressed, the in-flight frame completes intact.
- reset_n asserted mid-SHIFT at bit 10 -> immediately cs_n=1, sclk=0, sdi=0, busy=0. After release, first request comes 256 cycles later.
- DAC_OFFSET_BINARY_EN defined, ch0=0x00000000 -> SDI lane 0 decodes 0x800000. Undefined -> decodes 0x000000.

Source files
------------

// File: rtl/dac_frame_driver.sv
// dac_frame_driver
// Paces the DAC sample rate, captures one atomically updated 4-channel sample
// per period from the upstream de-interleaver and shifts it out to a 4-lane
// serial DAC (shared SCLK / CS_N / LDAC_N, one SDI line per channel).
// Missed samples are counted; on a miss no frame is sent, so the DAC keeps
// its last value.
// Optional build macro: DAC_OFFSET_BINARY_EN
//   defined   -> MSB of each channel field is inverted at capture
//                (two's complement to offset binary)
//   undefined -> data is shifted unmodified
module dac_frame_driver #(
  parameter int SAMPLE_DIV    = 256,
  parameter int SCLK_DIV      = 2,
  parameter int DATA_BITS     = 24,
  parameter int LDAC_CYCLES   = 2,
  parameter int READY_TIMEOUT = 8
) (
  input  logic         capture_clk,
  input  logic         reset_n,
  output logic         dac_request,
  input  logic         dac_buffer_ready,
  input  logic         dac_underrun,
  input  logic [127:0] dac_buffer_flat,
  output logic         dac_sclk,
  output logic         dac_cs_n,
  output logic [3:0]   dac_sdi,
  output logic         dac_ldac_n,
  output logic [15:0]  underrun_count,
  output logic         frame_overrun,
  output logic         busy
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int EDGE_W = $clog2(DATA_BITS + 1);
  localparam int LDAC_W = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;
  localparam int WAIT_W = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;

  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ZERO   = TICK_W'(0);
  localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ZERO    = DIV_W'(0);
  localparam logic [DIV_W-1:0]  DIV_ONE     = DIV_W'(1);
  localparam logic [EDGE_W-1:0] EDGE_LAST   = EDGE_W'(DATA_BITS - 1);
  localparam logic [EDGE_W-1:0] EDGE_ZERO   = EDGE_W'(0);
  localparam logic [EDGE_W-1:0] EDGE_ONE    = EDGE_W'(1);
  localparam logic [LDAC_W-1:0] LDAC_LAST   = LDAC_W'(LDAC_CYCLES - 1);
  localparam logic [LDAC_W-1:0] LDAC_ZERO   = LDAC_W'(0);
  localparam logic [LDAC_W-1:0] LDAC_ONE    = LDAC_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(READY_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO   = WAIT_W'(0);
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

  // Top DATA_BITS of a channel word, optionally re-coded to offset binary.
  function automatic logic [DATA_BITS-1:0] to_dac_code(input logic [31:0] word);
    logic [DATA_BITS-1:0] field;
    field = word[31 -: DATA_BITS];
`ifdef DAC_OFFSET_BINARY_EN
    field[DATA_BITS-1] = ~field[DATA_BITS-1];
`endif
    return field;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : (cnt + 16'd1);
  endfunction

  state_e                     state_q, state_d;
  logic [TICK_W-1:0]          tick_cnt_q, tick_cnt_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [EDGE_W-1:0]          edge_q, edge_d;
  logic [WAIT_W-1:0]          wait_q, wait_d;
  logic [LDAC_W-1:0]          ldac_cnt_q, ldac_cnt_d;
  logic [3:0][DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                       request_q, request_d;
  logic                       sclk_q, sclk_d;
  logic                       cs_n_q, cs_n_d;
  logic [3:0]                 sdi_q, sdi_d;
  logic                       ldac_n_q, ldac_n_d;
  logic [15:0]                ucnt_q, ucnt_d;
  logic                       overrun_q, overrun_d;
  logic                       busy_q, busy_d;

  logic                       tick_s;
  logic                       half_done_s;
  logic                       last_edge_s;
  logic                       wait_expire_s;
  logic                       load_done_s;
  logic [3:0][DATA_BITS-1:0]  capture_s;
  logic [3:0][DATA_BITS-1:0]  shifted_s;
  logic                       unused_flat_s;

  // Low bits of each channel word are below the DAC resolution.
  assign unused_flat_s = ^dac_buffer_flat;

  // Period tick and in-state progress flags derived from the counters.
  always_comb begin
    tick_s        = (tick_cnt_q == TICK_ZERO);
    half_done_s   = (div_q == DIV_LAST);
    last_edge_s   = half_done_s && sclk_q && (edge_q == EDGE_LAST);
    wait_expire_s = (wait_q == WAIT_LAST);
    load_done_s   = (ldac_cnt_q == LDAC_LAST);
    tick_cnt_d    = tick_s ? TICK_RELOAD : (tick_cnt_q - TICK_ONE);
  end

  // Per-channel capture words and the one-bit-advanced shift registers.
  always_comb begin
    capture_s = {(4 * DATA_BITS){1'b0}};
    shifted_s = {(4 * DATA_BITS){1'b0}};
    for (int c = 0; c < 4; c++) begin
      capture_s[c] = to_dac_code(dac_buffer_flat[32 * c +: 32]);
      shifted_s[c] = shreg_q[c] << 1;
    end
  end

  // Next-state logic of the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_s) state_d = ST_WAIT;
        else        state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (dac_buffer_ready)   state_d = ST_SHIFT;
        else if (dac_underrun)  state_d = ST_IDLE;
        else if (wait_expire_s) state_d = ST_IDLE;
        else                    state_d = ST_WAIT;
      end
      ST_SHIFT: begin
        if (last_edge_s) state_d = ST_LOAD;
        else             state_d = ST_SHIFT;
      end
      ST_LOAD: begin
        if (load_done_s) state_d = ST_IDLE;
        else             state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of outputs, shift registers and per-state counters.
  always_comb begin
    request_d  = 1'b0;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    sdi_d      = sdi_q;
    ldac_n_d   = ldac_n_q;
    ucnt_d     = ucnt_q;
    shreg_d    = shreg_q;
    div_d      = div_q;
    edge_d     = edge_q;
    wait_d     = wait_q;
    ldac_cnt_d = ldac_cnt_q;
    busy_d     = (state_d != ST_IDLE);
    if (tick_s && (state_q != ST_IDLE)) overrun_d = 1'b1;
    else                                overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        wait_d = WAIT_ZERO;
        if (tick_s) request_d = 1'b1;
        else        request_d = 1'b0;
      end
      ST_WAIT: begin
        if (dac_buffer_ready) begin
          shreg_d = capture_s;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          div_d   = DIV_ZERO;
          edge_d  = EDGE_ZERO;
          for (int c = 0; c < 4; c++) sdi_d[c] = capture_s[c][DATA_BITS-1];
        end else if (dac_underrun || wait_expire_s) begin
          ucnt_d = sat_inc16(ucnt_q);
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      ST_SHIFT: begin
        if (!half_done_s) begin
          div_d = div_q + DIV_ONE;
        end else if (!sclk_q) begin
          div_d  = DIV_ZERO;
          sclk_d = 1'b1;
        end else if (edge_q == EDGE_LAST) begin
          div_d      = DIV_ZERO;
          sclk_d     = 1'b0;
          cs_n_d     = 1'b1;
          sdi_d      = 4'b0000;
          ldac_n_d   = 1'b0;
          ldac_cnt_d = LDAC_ZERO;
        end else begin
          div_d   = DIV_ZERO;
          sclk_d  = 1'b0;
          edge_d  = edge_q + EDGE_ONE;
          shreg_d = shifted_s;
          for (int c = 0; c < 4; c++) sdi_d[c] = shifted_s[c][DATA_BITS-1];
        end
      end
      ST_LOAD: begin
        if (load_done_s) ldac_n_d = 1'b1;
        else             ldac_cnt_d = ldac_cnt_q + LDAC_ONE;
      end
      default: begin
        sclk_d   = 1'b0;
        cs_n_d   = 1'b1;
        sdi_d    = 4'b0000;
        ldac_n_d = 1'b1;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge capture_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge capture_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= TICK_RELOAD;
      div_q      <= DIV_ZERO;
      edge_q     <= EDGE_ZERO;
      wait_q     <= WAIT_ZERO;
      ldac_cnt_q <= LDAC_ZERO;
      shreg_q    <= {(4 * DATA_BITS){1'b0}};
      request_q  <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sdi_q      <= 4'b0000;
      ldac_n_q   <= 1'b1;
      ucnt_q     <= 16'h0000;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      wait_q     <= wait_d;
      ldac_cnt_q <= ldac_cnt_d;
      shreg_q    <= shreg_d;
      request_q  <= request_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      sdi_q      <= sdi_d;
      ldac_n_q   <= ldac_n_d;
      ucnt_q     <= ucnt_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  assign dac_request    = request_q;
  assign dac_sclk       = sclk_q;
  assign dac_cs_n       = cs_n_q;
  assign dac_sdi        = sdi_q;
  assign dac_ldac_n     = ldac_n_q;
  assign underrun_count = ucnt_q;
  assign frame_overrun  = overrun_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_dac_frame_driver.sv
// Self-checking bench for dac_frame_driver. Instance A uses default
// parameters; instance B uses SAMPLE_DIV=64 so ticks overlap frames.
// A serial-bus monitor decodes each frame from the pins; expected words come
// from a reference function applied to the words that were presented.
module tb_dac_frame_driver;
  localparam int DB = 24;

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [31:0] ZERO_CODE = 32'h0080_0000;
`else
  localparam logic [31:0] ZERO_CODE = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, reset_n_b, ready, underrun;
  logic [127:0] flat;

  logic a_req, a_sclk, a_cs_n, a_ldac_n, a_ovr, a_busy;
  logic b_req, b_sclk, b_cs_n, b_ldac_n, b_ovr, b_busy;
  logic [3:0]  a_sdi, b_sdi;
  logic [15:0] a_ucnt, b_ucnt;

  dac_frame_driver dut_a (
    .capture_clk(clk), .reset_n(reset_n), .dac_request(a_req),
    .dac_buffer_ready(ready), .dac_underrun(underrun), .dac_buffer_flat(flat),
    .dac_sclk(a_sclk), .dac_cs_n(a_cs_n), .dac_sdi(a_sdi), .dac_ldac_n(a_ldac_n),
    .underrun_count(a_ucnt), .frame_overrun(a_ovr), .busy(a_busy)
  );

  dac_frame_driver #(.SAMPLE_DIV(64)) dut_b (
    .capture_clk(clk), .reset_n(reset_n_b), .dac_request(b_req),
    .dac_buffer_ready(ready), .dac_underrun(underrun), .dac_buffer_flat(flat),
    .dac_sclk(b_sclk), .dac_cs_n(b_cs_n), .dac_sdi(b_sdi), .dac_ldac_n(b_ldac_n),
    .underrun_count(b_ucnt), .frame_overrun(b_ovr), .busy(b_busy)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] mon_sclk, mon_cs, mon_ldac, mon_rst, mon_req, mon_busy;
  logic [3:0] mon_sdi [2];
  assign mon_sclk = {b_sclk, a_sclk};
  assign mon_cs   = {b_cs_n, a_cs_n};
  assign mon_ldac = {b_ldac_n, a_ldac_n};
  assign mon_rst  = {reset_n_b, reset_n};
  assign mon_req  = {b_req, a_req};
  assign mon_busy = {b_busy, a_busy};
  assign mon_sdi[0] = a_sdi;
  assign mon_sdi[1] = b_sdi;

  logic        prev_sclk [2];
  logic        prev_cs   [2];
  logic        prev_ldac [2];
  logic [31:0] sh        [2][4];
  logic [31:0] last_word [2][4];
  int nbits[2]         = '{0, 0};
  int ldac_len[2]      = '{0, 0};
  int frame_cnt[2]     = '{0, 0};
  int last_bits[2]     = '{0, 0};
  int ldac_pulses[2]   = '{0, 0};
  int last_ldac_len[2] = '{0, 0};

  // Serial-bus decoder: collect SDI on SCLK rising edges while CS_N is low.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!mon_rst[d]) begin
        prev_sclk[d] = 1'b0; prev_cs[d] = 1'b1; prev_ldac[d] = 1'b1;
        nbits[d] = 0; ldac_len[d] = 0;
        for (int c = 0; c < 4; c++) sh[d][c] = 32'h0;
      end else begin
        if (!mon_cs[d] && prev_cs[d]) begin
          nbits[d] = 0;
          for (int c = 0; c < 4; c++) sh[d][c] = 32'h0;
        end
        if (!mon_cs[d] && mon_sclk[d] && !prev_sclk[d]) begin
          nbits[d]++;
          for (int c = 0; c < 4; c++) sh[d][c] = {sh[d][c][30:0], mon_sdi[d][c]};
        end
        if (mon_cs[d] && !prev_cs[d]) begin
          frame_cnt[d]++;
          last_bits[d] = nbits[d];
          for (int c = 0; c < 4; c++) last_word[d][c] = sh[d][c];
        end
        if (!mon_ldac[d]) ldac_len[d]++;
        else if (!prev_ldac[d]) begin
          ldac_pulses[d]++;
          last_ldac_len[d] = ldac_len[d];
          ldac_len[d] = 0;
        end
        prev_sclk[d] = mon_sclk[d]; prev_cs[d] = mon_cs[d]; prev_ldac[d] = mon_ldac[d];
      end
    end
  end

  // What the DAC should receive for one channel word.
  function automatic logic [31:0] model_word(input logic [31:0] ch);
    logic [31:0] w;
    w = ch >> (32 - DB);
`ifdef DAC_OFFSET_BINARY_EN
    w = w ^ (32'h1 << (DB - 1));
`endif
    return w;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_req(input int d, input int bound, output int cycles, output bit ok);
    cycles = 0; ok = 1'b0;
    while (!ok && cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (mon_req[d]) ok = 1'b1;
    end
  endtask

  // Called on the negedge where dac_request was seen; answers one cycle later.
  task automatic respond_frame(input int d, input logic [127:0] data, input bit with_underrun,
                               input string tag, output bit saw_req);
    int f0, p0, n;
    bit done;
    f0 = frame_cnt[d]; p0 = ldac_pulses[d]; saw_req = 1'b0;
    @(negedge clk);
    flat = data; ready = 1'b1; underrun = with_underrun;
    vectors++;
    if (mon_cs[d] !== 1'b1) begin miscompares++; $display("FAIL %s cs_n_early: got %b want 1", tag, mon_cs[d]); end
    @(negedge clk);
    ready = 1'b0; underrun = 1'b0; flat = rand128();
    vectors++;
    if (mon_cs[d] !== 1'b0) begin miscompares++; $display("FAIL %s cs_n_latency: got %b want 0", tag, mon_cs[d]); end
    n = 0; done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk); n++;
      if (mon_req[d]) saw_req = 1'b1;
      if (!mon_busy[d]) done = 1'b1;
    end
    vectors++;
    if (!done) begin miscompares++; $display("FAIL %s frame_end: busy still %b after %0d cycles", tag, mon_busy[d], n); end
    @(negedge clk);
    vectors++;
    if (frame_cnt[d] !== f0 + 1) begin miscompares++; $display("FAIL %s frame_count: got %0d want %0d", tag, frame_cnt[d], f0 + 1); end
    vectors++;
    if (last_bits[d] !== DB) begin miscompares++; $display("FAIL %s sclk_edges: got %0d want %0d", tag, last_bits[d], DB); end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (last_word[d][c] !== model_word(data[32 * c +: 32])) begin
        miscompares++;
        $display("FAIL %s word_ch%0d: got %h want %h", tag, c, last_word[d][c], model_word(data[32 * c +: 32]));
      end
    end
    vectors++;
    if (ldac_pulses[d] !== p0 + 1) begin miscompares++; $display("FAIL %s ldac_pulses: got %0d want %0d", tag, ldac_pulses[d], p0 + 1); end
    vectors++;
    if (last_ldac_len[d] !== 2) begin miscompares++; $display("FAIL %s ldac_len: got %0d want 2", tag, last_ldac_len[d]); end
  endtask

  task automatic do_reset_a();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_idle_pins_a(input string tag);
    vectors++;
    if ({a_req, a_cs_n, a_sclk, a_sdi, a_ldac_n, a_busy} !== {1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL %s pins req/cs_n/sclk/sdi/ldac_n/busy: got %b%b%b_%b%b%b want 010_000010",
               tag, a_req, a_cs_n, a_sclk, a_sdi, a_ldac_n, a_busy);
    end
  endtask

  task automatic test_reset();
    int cyc; bit ok, sr;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_pins_a("reset");
    vectors++;
    if (a_ucnt !== 16'h0) begin miscompares++; $display("FAIL reset underrun_count: got %h want 0000", a_ucnt); end
    vectors++;
    if (a_ovr !== 1'b0) begin miscompares++; $display("FAIL reset frame_overrun: got %b want 0", a_ovr); end
    reset_n = 1'b1;
    wait_req(0, 400, cyc, ok);
    vectors++;
    if (!ok || cyc != 256) begin miscompares++; $display("FAIL first_request: got cycle %0d (seen %0d) want 256", cyc, ok); end
    respond_frame(0, {32'h7FFFFF00, 32'h80000000, 32'hABCDEF00, 32'h12345600}, 1'b0, "plan_frame", sr);
  endtask

  task automatic test_frames();
    int cyc; bit ok, sr;
    for (int i = 0; i < 4; i++) begin
      wait_req(0, 300, cyc, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL rand_frame request: none in %0d cycles", cyc); end
      else respond_frame(0, rand128(), 1'b0, "rand_frame", sr);
    end
  endtask

  task automatic test_underrun();
    int cyc, f0; bit ok, sr;
    do_reset_a();
    wait_req(0, 300, cyc, ok);
    f0 = frame_cnt[0];
    @(negedge clk); underrun = 1'b1;
    @(negedge clk); underrun = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_pins_a("underrun");
    vectors++;
    if (a_ucnt !== 16'd1) begin miscompares++; $display("FAIL underrun count: got %0d want 1", a_ucnt); end
    vectors++;
    if (frame_cnt[0] !== f0) begin miscompares++; $display("FAIL underrun no_frame: got %0d frames want %0d", frame_cnt[0], f0); end
    ready = 1'b1; flat = rand128();
    @(negedge clk); ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_busy !== 1'b0) begin miscompares++; $display("FAIL idle_ready_ignored: busy %b want 0", a_busy); end
    wait_req(0, 300, cyc, ok);
    respond_frame(0, rand128(), 1'b1, "ready_priority", sr);
    vectors++;
    if (a_ucnt !== 16'd1) begin miscompares++; $display("FAIL ready_priority count: got %0d want 1", a_ucnt); end
  endtask

  task automatic test_timeout();
    int cyc, f0; bit ok;
    logic [15:0] u0;
    wait_req(0, 300, cyc, ok);
    u0 = a_ucnt; f0 = frame_cnt[0];
    repeat (6) @(negedge clk);
    vectors++;
    if (a_busy !== 1'b1) begin miscompares++; $display("FAIL timeout still_waiting: busy %b want 1", a_busy); end
    repeat (6) @(negedge clk);
    vectors++;
    if (a_busy !== 1'b0) begin miscompares++; $display("FAIL timeout idle: busy %b want 0", a_busy); end
    vectors++;
    if (a_ucnt !== u0 + 16'd1) begin miscompares++; $display("FAIL timeout count: got %0d want %0d", a_ucnt, u0 + 16'd1); end
    vectors++;
    if (frame_cnt[0] !== f0) begin miscompares++; $display("FAIL timeout no_frame: got %0d want %0d", frame_cnt[0], f0); end
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_busy !== 1'b0 || a_cs_n !== 1'b1) begin miscompares++; $display("FAIL late_ready_ignored: busy %b cs_n %b want 0 1", a_busy, a_cs_n); end
  endtask

  task automatic test_offset();
    int cyc; bit ok, sr;
    wait_req(0, 300, cyc, ok);
    respond_frame(0, {$urandom(), $urandom(), $urandom(), 32'h0}, 1'b0, "zero_ch0", sr);
    vectors++;
    if (last_word[0][0] !== ZERO_CODE) begin miscompares++; $display("FAIL zero_ch0 code: got %h want %h", last_word[0][0], ZERO_CODE); end
  endtask

  task automatic test_mid_reset();
    int cyc; bit ok;
    wait_req(0, 300, cyc, ok);
    @(negedge clk); ready = 1'b1; flat = rand128();
    @(negedge clk); ready = 1'b0;
    repeat (41) @(negedge clk);
    vectors++;
    if (a_cs_n !== 1'b0 || a_busy !== 1'b1) begin miscompares++; $display("FAIL mid_shift precondition: cs_n %b busy %b want 0 1", a_cs_n, a_busy); end
    #2 reset_n = 1'b0;
    #1 check_idle_pins_a("mid_reset");
    @(negedge clk); reset_n = 1'b1;
    wait_req(0, 400, cyc, ok);
    vectors++;
    if (!ok || cyc != 256) begin miscompares++; $display("FAIL mid_reset request: got cycle %0d want 256", cyc); end
  endtask

  task automatic test_overrun();
    int cyc, f0; bit ok, sr;
    logic [127:0] data;
    reset_n = 1'b0;
    @(negedge clk); reset_n_b = 1'b1;
    wait_req(1, 200, cyc, ok);
    vectors++;
    if (!ok || cyc != 64) begin miscompares++; $display("FAIL ovr first_request: got cycle %0d want 64", cyc); end
    vectors++;
    if (b_ovr !== 1'b0) begin miscompares++; $display("FAIL ovr early: got %b want 0", b_ovr); end
    data = rand128();
    respond_frame(1, data, 1'b0, "ovr_frame", sr);
    vectors++;
    if (sr !== 1'b0) begin miscompares++; $display("FAIL ovr request_suppressed: got %b want 0", sr); end
    vectors++;
    if (b_ovr !== 1'b1) begin miscompares++; $display("FAIL ovr sticky_set: got %b want 1", b_ovr); end
    f0 = frame_cnt[1];
    wait_req(1, 80, cyc, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ovr next_tick: no request in %0d cycles", cyc); end
    vectors++;
    if (b_ovr !== 1'b1 || frame_cnt[1] !== f0) begin miscompares++; $display("FAIL ovr after: ovr %b frames %0d want 1 %0d", b_ovr, frame_cnt[1], f0); end
    reset_n_b = 1'b0;
    #1;
    vectors++;
    if (b_ovr !== 1'b0) begin miscompares++; $display("FAIL ovr reset_clear: got %b want 0", b_ovr); end
  endtask

  initial begin
    reset_n = 1'b0; reset_n_b = 1'b0; ready = 1'b0; underrun = 1'b0; flat = 128'h0;
    @(negedge clk);
    test_reset();
    test_frames();
    test_underrun();
    test_timeout();
    test_offset();
    test_mid_reset();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
